traffic_light: RTL and testbench



---
 rtl/traffic_light.sv | 136 +++++++++++++
 tb/tb_traffic_light.sv | 138 +++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// Two-way traffic light controller: six-phase Moore FSM (NS green/yellow/all-red,
// EW green/yellow/all-red) with a clock prescaler driving programmable phase lengths.
module traffic_light #(
  parameter int TICK_DIV     = 1,
  parameter int DELAY_GREEN  = 15,
  parameter int DELAY_YELLOW = 3,
  parameter int DELAY_ALLRED = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic R1,
  output logic Y1,
  output logic G1,
  output logic R2,
  output logic Y2,
  output logic G2
);

  typedef enum logic [2:0] {
    NS_GRN    = 3'd0,
    NS_YEL    = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GRN    = 3'd3,
    EW_YEL    = 3'd4,
    ALL_RED_B = 3'd5
  } state_t;

  // A zero delay or divider is treated as one so every phase lasts at least one tick.
  localparam int unsigned DIV_EFF = (TICK_DIV     < 1) ? 1 : TICK_DIV;
  localparam int unsigned GRN_EFF = (DELAY_GREEN  < 1) ? 1 : DELAY_GREEN;
  localparam int unsigned YEL_EFF = (DELAY_YELLOW < 1) ? 1 : DELAY_YELLOW;
  localparam int unsigned RED_EFF = (DELAY_ALLRED < 1) ? 1 : DELAY_ALLRED;

  localparam logic [31:0] DIV_LAST = 32'(DIV_EFF - 1);
  localparam logic [31:0] GRN_LAST = 32'(GRN_EFF - 1);
  localparam logic [31:0] YEL_LAST = 32'(YEL_EFF - 1);
  localparam logic [31:0] RED_LAST = 32'(RED_EFF - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] psc;
  logic [31:0] phase_last;
  logic        tick;
  logic        illegal;

  // Prescaler: one tick every DIV_EFF clocks
  assign tick = (psc == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 32'd1;
    end
  end

  // Phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NS_GRN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    phase_last = '0;
    illegal    = 1'b0;

    case (state)
      NS_GRN:    phase_last = GRN_LAST;
      NS_YEL:    phase_last = YEL_LAST;
      ALL_RED_A: phase_last = RED_LAST;
      EW_GRN:    phase_last = GRN_LAST;
      EW_YEL:    phase_last = YEL_LAST;
      ALL_RED_B: phase_last = RED_LAST;
      default:   illegal    = 1'b1;
    endcase

    if (illegal) begin
      state_nxt = NS_GRN;
      cnt_nxt   = '0;
    end else if (tick) begin
      if (cnt == phase_last) begin
        cnt_nxt = '0;
        case (state)
          NS_GRN:    state_nxt = NS_YEL;
          NS_YEL:    state_nxt = ALL_RED_A;
          ALL_RED_A: state_nxt = EW_GRN;
          EW_GRN:    state_nxt = EW_YEL;
          EW_YEL:    state_nxt = ALL_RED_B;
          default:   state_nxt = NS_GRN;
        endcase
      end else begin
        cnt_nxt = cnt + 32'd1;
      end
    end
  end

  // Lamp decode straight from the state register; unknown codes show all red.
  always_comb begin
    R1 = 1'b1;
    Y1 = 1'b0;
    G1 = 1'b0;
    R2 = 1'b1;
    Y2 = 1'b0;
    G2 = 1'b0;
    case (state)
      NS_GRN: begin
        R1 = 1'b0;
        G1 = 1'b1;
      end
      NS_YEL: begin
        R1 = 1'b0;
        Y1 = 1'b1;
      end
      EW_GRN: begin
        R2 = 1'b0;
        G2 = 1'b1;
      end
      EW_YEL: begin
        R2 = 1'b0;
        Y2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: three instances (defaults, TICK_DIV=4, short
// delays) share one clock and reset and are checked against a phase-timing model.
module tb_traffic_light;

  // Lamp vectors ordered {R1,Y1,G1,R2,Y2,G2}
  localparam logic [5:0] P0 = 6'b001_100;
  localparam logic [5:0] P1 = 6'b010_100;
  localparam logic [5:0] P2 = 6'b100_100;
  localparam logic [5:0] P3 = 6'b100_001;
  localparam logic [5:0] P4 = 6'b100_010;
  localparam logic [5:0] P5 = 6'b100_100;

  logic clk;
  logic rst_n;
  logic ar1, ay1, ag1, ar2, ay2, ag2;
  logic br1, by1, bg1, br2, by2, bg2;
  logic cr1, cy1, cg1, cr2, cy2, cg2;
  logic [5:0] la, lb, lc;

  int checks = 0;
  int errors = 0;

  traffic_light #(.TICK_DIV(1), .DELAY_GREEN(15), .DELAY_YELLOW(3), .DELAY_ALLRED(3)) u_def (
    .clk(clk), .rst_n(rst_n),
    .R1(ar1), .Y1(ay1), .G1(ag1), .R2(ar2), .Y2(ay2), .G2(ag2)
  );

  traffic_light #(.TICK_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n),
    .R1(br1), .Y1(by1), .G1(bg1), .R2(br2), .Y2(by2), .G2(bg2)
  );

  traffic_light #(.TICK_DIV(1), .DELAY_GREEN(2), .DELAY_YELLOW(1), .DELAY_ALLRED(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .R1(cr1), .Y1(cy1), .G1(cg1), .R2(cr2), .Y2(cy2), .G2(cg2)
  );

  assign la = {ar1, ay1, ag1, ar2, ay2, ag2};
  assign lb = {br1, by1, bg1, br2, by2, bg2};
  assign lc = {cr1, cy1, cg1, cr2, cy2, cg2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lamps n edges after reset release, from cumulative phase durations.
  function automatic logic [5:0] model(int n, int div, int dg, int dy, int dr);
    int g, y, r, t;
    g = (dg < 1) ? 1 : dg;
    y = (dy < 1) ? 1 : dy;
    r = (dr < 1) ? 1 : dr;
    t = (n / div) % (2 * (g + y + r));
    if (t < g)                  return P0;
    else if (t < g + y)         return P1;
    else if (t < g + y + r)     return P2;
    else if (t < 2*g + y + r)   return P3;
    else if (t < 2*g + 2*y + r) return P4;
    else                        return P5;
  endfunction

  function automatic logic safe(logic [5:0] l);
    logic [2:0] ns, ew;
    ns = l[5:3];
    ew = l[2:0];
    return !((ns[0] | ns[1]) && (ew[0] | ew[1])) && $onehot(ns) && $onehot(ew);
  endfunction

  task automatic check_all(input string ph, input int n);
    chk($sformatf("%s_def_e%0d", ph, n), {26'd0, la}, {26'd0, model(n, 1, 15, 3, 3)});
    chk($sformatf("%s_div4_e%0d", ph, n), {26'd0, lb}, {26'd0, model(n, 4, 15, 3, 3)});
    chk($sformatf("%s_fast_e%0d", ph, n), {26'd0, lc}, {26'd0, model(n, 1, 2, 1, 1)});
    chk($sformatf("%s_safe_e%0d", ph, n), {31'd0, safe(la) & safe(lb) & safe(lc)}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    // Lamps valid before any clock edge
    chk("rst_noclk_def", {26'd0, la}, {26'd0, P0});
    chk("rst_noclk_div4", {26'd0, lb}, {26'd0, P0});
    chk("rst_noclk_fast", {26'd0, lc}, {26'd0, P0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold_%0d", i), {26'd0, la}, {26'd0, P0});
    end

    // Release and run long enough to see a full TICK_DIV=4 cycle and beyond
    rst_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("run", n);
      if (n == 15) chk("def_e15_yellow", {26'd0, la}, {26'd0, P1});
      if (n == 42) chk("def_e42_wrap", {26'd0, la}, {26'd0, P0});
      if (n == 59) chk("div4_e59_green", {26'd0, lb}, {26'd0, P0});
      if (n == 60) chk("div4_e60_yellow", {26'd0, lb}, {26'd0, P1});
      if (n == 168) chk("div4_e168_wrap", {26'd0, lb}, {26'd0, P0});
      if (n == 8) chk("fast_e8_wrap", {26'd0, lc}, {26'd0, P0});
    end

    // Restart, run into the EW-yellow phase, then pulse reset mid-phase
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 37; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("pre", n);
    end
    chk("pre_state4", {26'd0, la}, {26'd0, P4});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async_def", {26'd0, la}, {26'd0, P0});
    chk("mid_rst_async_div4", {26'd0, lb}, {26'd0, P0});
    chk("mid_rst_async_fast", {26'd0, lc}, {26'd0, P0});
    @(negedge clk);
    chk("mid_rst_hold", {26'd0, la}, {26'd0, P0});
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("post", n);
      if (n == 14) chk("post_e14_green", {26'd0, la}, {26'd0, P0});
      if (n == 15) chk("post_e15_yellow", {26'd0, la}, {26'd0, P1});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
